// File: rtl/dbscan_core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dbscan_core_scheduler
//  Purpose  : Walks every (i, j) point pair through an external distance unit,
//             counts neighbours within EPS2 for each reference point i, and
//             writes one core flag per point (count >= MIN_PTS).
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, num_points   - pass request and point count
//             dist_req/dist_gnt   - distance-unit handshake
//             i_addr, j_addr      - pair addresses presented to the unit
//             dist2               - squared distance of the presented pair
//             we_core, core_addr,
//             core_val            - core-flag write port
//             busy, done          - pass status
//  Revision : 1.0 - initial release
// ============================================================================
module dbscan_core_scheduler #(
    parameter int          MAX_N   = 64,
    parameter logic [17:0] EPS2    = 18'd100,
    parameter int          MIN_PTS = 4,
    parameter int          AW      = $clog2(MAX_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    num_points,
    input  logic          dist_gnt,
    input  logic [17:0]   dist2,
    output logic [AW-1:0] i_addr,
    output logic [AW-1:0] j_addr,
    output logic          dist_req,
    output logic          we_core,
    output logic [AW-1:0] core_addr,
    output logic          core_val,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] C_MAX_N   = 8'(MAX_N);
    localparam logic [7:0] C_MIN_PTS = 8'(MIN_PTS);
    localparam int         C_PAD     = 8 - AW;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [7:0]    r_n;
    logic [AW-1:0] r_i;
    logic [AW-1:0] r_j;
    logic [7:0]    r_count;
    // Last addresses driven while scanning; presented outside SCAN so the
    // distance unit sees stable addresses.
    logic [AW-1:0] r_i_hold;
    logic [AW-1:0] r_j_hold;

    logic [7:0]    w_n_start;
    logic          w_last_j;
    logic          w_last_i;
    logic          w_near;

    assign w_n_start = (num_points > C_MAX_N) ? C_MAX_N : num_points;
    assign w_last_j  = ({{C_PAD{1'b0}}, r_j} == (r_n - 8'd1));
    assign w_last_i  = ({{C_PAD{1'b0}}, r_i} == (r_n - 8'd1));
    assign w_near    = (dist2 <= EPS2);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        dist_req     = 1'b0;
        we_core      = 1'b0;
        core_val     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        i_addr       = r_i_hold;
        j_addr       = r_j_hold;
        core_addr    = r_i;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = (w_n_start == 8'd0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                dist_req = 1'b1;
                i_addr   = r_i;
                j_addr   = r_j;
                if (dist_gnt && w_last_j) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                we_core      = 1'b1;
                core_val     = (r_count >= C_MIN_PTS);
                w_next_state = w_last_i ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Pair counters, neighbour count and held addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n      <= 8'd0;
            r_i      <= '0;
            r_j      <= '0;
            r_count  <= 8'd0;
            r_i_hold <= '0;
            r_j_hold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= w_n_start;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_count <= 8'd0;
                    end
                end
                S_SCAN: begin
                    r_i_hold <= r_i;
                    r_j_hold <= r_j;
                    if (dist_gnt) begin
                        // Self pair (j == i) has dist2 = 0 and is counted.
                        if (w_near) begin
                            r_count <= r_count + 8'd1;
                        end
                        r_j <= r_j + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!w_last_i) begin
                        r_i     <= r_i + 1'b1;
                        r_j     <= '0;
                        r_count <= 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbscan_core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbscan_core_scheduler
//  Purpose  : Scoreboard bench for dbscan_core_scheduler. A reference model
//             counts neighbours per point from the pair-distance rule and
//             predicts the write sequence and the done cycle; a monitor pops
//             and compares whenever the DUT writes or signals done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbscan_core_scheduler;

    localparam int          MAX_N   = 64;
    localparam logic [17:0] EPS2    = 18'd100;
    localparam int          MIN_PTS = 2;
    localparam int          AW      = 6;
    localparam int          GLEN    = 16384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    num_points = 8'd0;
    logic          dist_gnt = 1'b1;
    logic [17:0]   dist2 = 18'd0;
    logic [AW-1:0] i_addr, j_addr, core_addr;
    logic          dist_req, we_core, core_val, busy, done;

    dbscan_core_scheduler #(
        .MAX_N(MAX_N), .EPS2(EPS2), .MIN_PTS(MIN_PTS), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points),
        .dist_gnt(dist_gnt), .dist2(dist2), .i_addr(i_addr), .j_addr(j_addr),
        .dist_req(dist_req), .we_core(we_core), .core_addr(core_addr),
        .core_val(core_val), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int accept_edge = 0;
    int done_seen = 0;
    int px[MAX_N];
    int py[MAX_N];
    int dmode  = 0;   // 0: geometric points, 1: constant off-diagonal distance
    int dconst = 0;
    bit gnt_seq[GLEN];

    typedef struct { int addr; int val; } wr_t;
    wr_t exp_wr[$];
    int  exp_done[$];

    bit  hold_pending = 1'b0;
    int  hold_i, hold_j;

    function automatic int ref_d2(int a, int b);
        int dx, dy;
        if (a == b) return 0;
        if (dmode == 1) return dconst;
        dx = px[a] - px[b];
        dy = py[a] - py[b];
        return dx * dx + dy * dy;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: neighbour counts per point and the done cycle, counted
    // in clock edges after the start-accept edge.
    task automatic build_expect(int nreq);
        int n, cnt, k;
        n = (nreq > MAX_N) ? MAX_N : nreq;
        for (int i = 0; i < n; i++) begin
            wr_t w;
            cnt = 0;
            for (int j = 0; j < n; j++)
                if (ref_d2(i, j) <= int'(EPS2)) cnt++;
            w.addr = i;
            w.val  = (cnt >= MIN_PTS) ? 1 : 0;
            exp_wr.push_back(w);
        end
        k = 1;
        for (int p = 0; p < n * n; p++) begin
            while (k < GLEN && !gnt_seq[k]) k++;
            k++;
            if ((p % n) == n - 1) k++;   // one WRITE cycle after each row
        end
        exp_done.push_back(k);
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    // Distance unit and grant driver: react to the addresses of this cycle.
    always @(posedge clk) begin
        int idx;
        #2;
        dist2 = 18'(ref_d2(int'(i_addr), int'(j_addr)));
        idx = edge_n - accept_edge + 1;
        dist_gnt = (idx >= 0 && idx < GLEN) ? gnt_seq[idx] : 1'b1;
    end

    // Monitor
    always @(negedge clk) begin
        if (hold_pending) begin
            check("held_i_addr", int'(i_addr), hold_i);
            check("held_j_addr", int'(j_addr), hold_j);
        end
        hold_pending = dist_req && !dist_gnt;
        hold_i = int'(i_addr);
        hold_j = int'(j_addr);
        if (we_core) begin
            if (exp_wr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write: got addr %0d, expected no write", core_addr);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("write_addr", int'(core_addr), e.addr);
                check("write_val", int'(core_val), e.val);
            end
        end
        if (done) begin
            check("busy_at_done", int'(busy), 1);
            if (exp_done.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done: got done, expected none");
            end else begin
                // done is visible in the cycle that ends on the counted edge
                check("done_cycle", edge_n - accept_edge + 1, exp_done.pop_front());
            end
            done_seen++;
        end
    end

    task automatic fill_gnt(int gm);
        for (int k = 0; k < GLEN; k++) begin
            case (gm)
                1:       gnt_seq[k] = (k % 2) == 1;
                2:       gnt_seq[k] = ($urandom_range(3) != 0);
                default: gnt_seq[k] = 1'b1;
            endcase
        end
    endtask

    task automatic random_points(int span);
        for (int p = 0; p < MAX_N; p++) begin
            px[p] = $urandom_range(span);
            py[p] = $urandom_range(span);
        end
    endtask

    task automatic issue_start(int nreq);
        @(posedge clk); #1;
        start = 1'b1;
        num_points = 8'(nreq);
        @(posedge clk); #1;
        accept_edge = edge_n;
        start = 1'b0;
        num_points = 8'($urandom);
    endtask

    task automatic run_pass(int nreq, int dm, int dc, int gm, bit poke);
        int seen0, t;
        dmode = dm; dconst = dc;
        fill_gnt(gm);
        build_expect(nreq);
        issue_start(nreq);
        if (poke) begin
            // A start with a different count mid-pass must be ignored.
            repeat (2) @(posedge clk);
            #1; start = 1'b1; num_points = 8'd5;
            @(posedge clk); #1; start = 1'b0;
        end
        seen0 = done_seen - ((exp_done.size() == 0) ? 1 : 0);
        t = 0;
        while (done_seen == seen0 && t < 20000) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 20000) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
        end
        @(negedge clk); #1;
        check("idle_busy", int'(busy), 0);
        check("writes_left", exp_wr.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we_core", int'(we_core), 0);
        check("rst_dist_req", int'(dist_req), 0);
        check("rst_i_addr", int'(i_addr), 0);
        check("rst_j_addr", int'(j_addr), 0);
        check("rst_core_addr", int'(core_addr), 0);
        check("rst_core_val", int'(core_val), 0);
    endtask

    initial begin
        int t;
        fill_gnt(0);
        random_points(20);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        // Two points, all distances zero, continuous grant
        run_pass(2, 1, 0, 0, 1'b0);
        // Three points, far apart off-diagonal
        run_pass(3, 1, 200, 0, 1'b0);
        // Two points, alternating grant
        run_pass(2, 1, 0, 1, 1'b0);
        // Empty pass
        run_pass(0, 1, 0, 0, 1'b0);
        // Count above MAX_N is clamped
        random_points(30);
        run_pass(200, 0, 0, 0, 1'b0);

        // Randomised passes with random grant
        for (int r = 0; r < 6; r++) begin
            random_points($urandom_range(8, 30));
            run_pass($urandom_range(2, 12), 0, 0, 2, (r == 2));
        end

        // Reset during WRITE of point 1 in an N=4 pass
        random_points(20);
        dmode = 0;
        fill_gnt(0);
        build_expect(4);
        issue_start(4);
        t = 0;
        while (!(we_core && core_addr == 6'd1) && t < 2000) begin
            @(negedge clk); t++;
        end
        check("reached_write1", int'(t < 2000), 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wr.delete();
        exp_done.delete();
        @(negedge clk);
        check_reset_outputs();
        repeat (30) @(negedge clk);
        check("no_resume_busy", int'(busy), 0);

        // Fresh pass; neighbours at exactly EPS2 are counted
        for (int p = 0; p < MAX_N; p++) begin px[p] = 0; py[p] = 0; end
        px[0] = 0; px[1] = 10; px[2] = 20; px[3] = 40;
        run_pass(4, 0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
